// File: rtl/enable_sequencer_pkg.sv
// Shared types and helpers for the enable sequencer.
// Pure declarations; no state, no flow control.
package enable_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } seq_state_e;

    localparam int unsigned MAX_CH = 32;

    // Thermometer code: bit k is set when more than k channels are enabled.
    function automatic logic [MAX_CH-1:0] therm(input int unsigned stage);
        logic [MAX_CH-1:0] code;
        for (int unsigned k = 0; k < MAX_CH; k++) begin
            code[k] = (stage > k);
        end
        return code;
    endfunction

endpackage

// File: rtl/seq_step_timer.sv
// Counts timebase ticks and flags when the programmed inter-step spacing has elapsed.
// step_o is combinational from the count; no backpressure, clr_i overrides counting.
module seq_step_timer #(
    parameter int DLY_W = 8
) (
    input  logic             clk_i,
    input  logic             arst_ni,
    input  logic             clr_i,
    input  logic             tick_i,
    input  logic [DLY_W-1:0] dly_i,
    output logic             step_o
);

    logic [DLY_W-1:0] cnt_q;
    logic [DLY_W:0]   cnt_inc;

    // The tick being presented counts toward the spacing, so dly_i ticks make one step.
    assign cnt_inc = {1'b0, cnt_q} + (DLY_W+1)'(1);
    assign step_o  = (dly_i == '0) || (tick_i && (cnt_inc == {1'b0, dly_i}));

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            cnt_q <= '0;
        end else if (clr_i || step_o) begin
            cnt_q <= '0;
        end else if (tick_i) begin
            cnt_q <= cnt_inc[DLY_W-1:0];
        end
    end

endmodule

// File: rtl/enable_sequencer.sv
// Ramps NUM_CH thermometer-coded enables up (low first) and down (high first) with tick spacing.
// Outputs registered, 1 cycle after a request is sampled; no backpressure, stop beats start.
module enable_sequencer
    import enable_sequencer_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int DLY_W  = 8
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    input  logic                       tick_i,
    input  logic                       start_i,
    input  logic                       stop_i,
    input  logic [DLY_W-1:0]           dly_i,
    output logic [NUM_CH-1:0]          en_o,
    output logic [$clog2(NUM_CH+1)-1:0] stage_o,
    output logic                       busy_o,
    output logic                       up_done_o,
    output logic                       down_done_o
);

    localparam int SW = $clog2(NUM_CH+1);
    localparam logic [SW-1:0] FULL = SW'(NUM_CH);

    seq_state_e       state_q, state_d;
    logic [SW-1:0]    stage_d, stage_inc, stage_dec;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             clr, step, up_done_d, down_done_d;

    assign stage_inc = (stage_o == FULL) ? stage_o : stage_o + SW'(1);
    assign stage_dec = (stage_o == '0)   ? stage_o : stage_o - SW'(1);

    seq_step_timer #(.DLY_W(DLY_W)) u_timer (
        .clk_i   (clk_i),
        .arst_ni (arst_ni),
        .clr_i   (clr),
        .tick_i  (tick_i),
        .dly_i   (dly_q),
        .step_o  (step)
    );

    always_comb begin
        state_d     = state_q;
        stage_d     = stage_o;
        dly_d       = dly_q;
        clr         = 1'b0;
        up_done_d   = 1'b0;
        down_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (start_i && !stop_i) begin
                    state_d = RAMP_UP;
                    stage_d = stage_inc;
                    dly_d   = dly_i;
                end
            end
            RAMP_UP: begin
                if (stop_i) begin
                    state_d = RAMP_DOWN;
                    stage_d = stage_dec;
                    dly_d   = dly_i;
                    clr     = 1'b1;
                end else if (step) begin
                    stage_d = stage_inc;
                end
            end
            ON: begin
                clr = 1'b1;
                if (stop_i) begin
                    state_d = RAMP_DOWN;
                    stage_d = stage_dec;
                    dly_d   = dly_i;
                end
            end
            RAMP_DOWN: begin
                if (start_i && !stop_i) begin
                    state_d = RAMP_UP;
                    stage_d = stage_inc;
                    dly_d   = dly_i;
                    clr     = 1'b1;
                end else if (step) begin
                    stage_d = stage_dec;
                end
            end
            default: state_d = IDLE;
        endcase
        // Ramps, including aborted ones, terminate as soon as the end stage is reached.
        if (state_d == RAMP_UP && stage_d == FULL) begin
            state_d   = ON;
            up_done_d = 1'b1;
        end
        if (state_d == RAMP_DOWN && stage_d == '0) begin
            state_d     = IDLE;
            down_done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!arst_ni) begin
            state_q     <= IDLE;
            stage_o     <= '0;
            dly_q       <= '0;
            en_o        <= '0;
            busy_o      <= 1'b0;
            up_done_o   <= 1'b0;
            down_done_o <= 1'b0;
        end else begin
            state_q     <= state_d;
            stage_o     <= stage_d;
            dly_q       <= dly_d;
            en_o        <= NUM_CH'(therm(32'(stage_d)));
            busy_o      <= (state_d == RAMP_UP) || (state_d == RAMP_DOWN);
            up_done_o   <= up_done_d;
            down_done_o <= down_done_d;
        end
    end

    assert property (@(posedge clk_i) disable iff (!arst_ni) stage_o <= FULL);

endmodule

// File: tb/tb_enable_sequencer.sv
// Directed bench for enable_sequencer with a per-cycle behavioural model and literal checks.
module tb_enable_sequencer;

    localparam int NUM_CH = 4;
    localparam int DLY_W  = 8;
    localparam int SW     = 3;

    logic              clk = 1'b0;
    logic              arst_n = 1'b0;
    logic              tick = 1'b0;
    logic              start = 1'b0;
    logic              stop = 1'b0;
    logic [DLY_W-1:0]  dly = '0;
    logic [NUM_CH-1:0] en;
    logic [SW-1:0]     stage;
    logic              busy, up_done, down_done;

    int n_chk = 0, n_err = 0;
    int n_up = 0, n_dn = 0, tick_cnt = 0, tick_mode = 0, tick_phase = 0, n_cyc = 0;

    // Model: number of enabled channels, ramp direction, ticks since last step.
    int m_stage = 0, m_dir = 0, m_ticks = 0, m_dly = 0;
    bit m_up = 1'b0, m_dn = 1'b0;

    enable_sequencer #(.NUM_CH(NUM_CH), .DLY_W(DLY_W)) dut (
        .clk_i       (clk),
        .arst_ni     (arst_n),
        .tick_i      (tick),
        .start_i     (start),
        .stop_i      (stop),
        .dly_i       (dly),
        .en_o        (en),
        .stage_o     (stage),
        .busy_o      (busy),
        .up_done_o   (up_done),
        .down_done_o (down_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, n_cyc);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_en(input logic [NUM_CH-1:0] v, input int lim, input string nm);
        for (int i = 0; i < lim && en !== v; i++) cyc(1);
        chk(nm, 32'(en), 32'(v));
    endtask

    always begin
        @(posedge clk);
        #1;
        case (tick_mode)
            1: tick = 1'b1;
            2: tick = 1'($urandom_range(0, 1));
            3: begin
                tick = (tick_phase == 2);
                tick_phase = (tick_phase + 1) % 3;
            end
            default: tick = 1'b0;
        endcase
    end

    always @(posedge clk) begin : model
        bit adv;
        adv  = 1'b0;
        m_up = 1'b0;
        m_dn = 1'b0;
        n_cyc++;
        if (tick) tick_cnt++;
        if (!arst_n) begin
            m_stage = 0; m_dir = 0; m_ticks = 0; m_dly = 0;
        end else begin
            if (stop && m_stage > 0 && m_dir != -1) begin
                m_dir = -1; m_dly = int'(dly); m_ticks = 0; adv = 1'b1;
            end else if (start && !stop && m_stage < NUM_CH && m_dir != 1) begin
                m_dir = 1; m_dly = int'(dly); m_ticks = 0; adv = 1'b1;
            end else if (m_dir != 0) begin
                if (tick) m_ticks++;
                if (m_dly == 0 || (tick && m_ticks == m_dly)) begin
                    adv = 1'b1; m_ticks = 0;
                end
            end
            if (adv) begin
                m_stage += m_dir;
                if (m_stage == NUM_CH) begin m_dir = 0; m_up = 1'b1; end
                if (m_stage == 0)      begin m_dir = 0; m_dn = 1'b1; end
            end
        end
    end

    always @(negedge clk) begin
        if (n_cyc > 0) begin
            chk("model_en",    32'(en),        32'((1 << m_stage) - 1));
            chk("model_stage", 32'(stage),     32'(m_stage));
            chk("model_busy",  32'(busy),      32'(m_dir != 0));
            chk("model_up",    32'(up_done),   32'(m_up));
            chk("model_down",  32'(down_done), 32'(m_dn));
            if (up_done)   n_up++;
            if (down_done) n_dn++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin
        int up0, dn0, tlast;
        logic [NUM_CH-1:0] prev;

        cyc(2);
        chk("rst_en", 32'(en), 32'h0);
        chk("rst_stage", 32'(stage), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        arst_n = 1'b1;

        // Ramp-up, 2 ticks per step, tick every 3rd cycle.
        up0 = n_up;
        dly = 8'd2; tick_mode = 3; start = 1'b1;
        cyc(1);
        chk("up_first_en", 32'(en), 32'h1);
        chk("up_first_busy", 32'(busy), 32'h1);
        tlast = tick_cnt;
        prev  = en;
        for (int i = 0; i < 60; i++) begin
            cyc(1);
            if (en !== prev) begin
                chk("up_step_ticks", 32'(tick_cnt - tlast), 32'd2);
                chk("up_step_code", 32'(en), 32'((prev << 1) | 4'h1));
                tlast = tick_cnt;
                prev  = en;
                if (en === 4'hf) begin
                    chk("up_done_at_full", 32'(up_done), 32'h1);
                    break;
                end
            end
        end
        chk("up_reached_full", 32'(en), 32'hf);
        cyc(1);
        chk("on_busy", 32'(busy), 32'h0);
        chk("up_done_single", 32'(n_up - up0), 32'd1);

        // Zero delay both ways.
        dly = 8'd0; tick_mode = 0; start = 1'b0; stop = 1'b1;
        cyc(1); chk("z_dn_0111", 32'(en), 32'h7);
        cyc(1); chk("z_dn_0011", 32'(en), 32'h3);
        cyc(1); chk("z_dn_0001", 32'(en), 32'h1);
        cyc(1); chk("z_dn_0000", 32'(en), 32'h0);
        chk("z_dn_done", 32'(down_done), 32'h1);
        stop = 1'b0; start = 1'b1;
        cyc(1); chk("z_up_0001", 32'(en), 32'h1);
        cyc(1); chk("z_up_0011", 32'(en), 32'h3);
        cyc(1); chk("z_up_0111", 32'(en), 32'h7);
        cyc(1); chk("z_up_1111", 32'(en), 32'hf);
        chk("z_up_done", 32'(up_done), 32'h1);

        // Abort during ramp-up.
        start = 1'b0; stop = 1'b1;
        wait_en(4'h0, 10, "ab_prep_idle");
        cyc(1);
        stop = 1'b0; dly = 8'd3; tick_mode = 1; start = 1'b1;
        up0 = n_up; dn0 = n_dn;
        wait_en(4'h3, 20, "ab_reach_0011");
        start = 1'b0; stop = 1'b1;
        cyc(1); chk("ab_first_dec", 32'(en), 32'h1);
        cyc(2); chk("ab_hold", 32'(en), 32'h1);
        cyc(1); chk("ab_zero", 32'(en), 32'h0);
        chk("ab_down_done", 32'(down_done), 32'h1);
        cyc(1);
        chk("ab_no_up_done", 32'(n_up - up0), 32'd0);
        chk("ab_one_down_done", 32'(n_dn - dn0), 32'd1);

        // Abort during ramp-down, then simultaneous requests.
        stop = 1'b0; dly = 8'd0; tick_mode = 0; start = 1'b1;
        wait_en(4'hf, 10, "ad_reach_on");
        dly = 8'd2; tick_mode = 3; start = 1'b0; stop = 1'b1;
        cyc(1); chk("ad_0111", 32'(en), 32'h7);
        start = 1'b1; stop = 1'b0;
        cyc(1); chk("ad_back_full", 32'(en), 32'hf);
        chk("ad_up_done", 32'(up_done), 32'h1);
        stop = 1'b1;
        cyc(1); chk("both_dn_0111", 32'(en), 32'h7);
        chk("both_busy", 32'(busy), 32'h1);
        start = 1'b0;
        wait_en(4'h0, 60, "both_idle");
        chk("both_down_done", 32'(down_done), 32'h1);

        // Synchronous reset mid-ramp, then a glitch between edges.
        stop = 1'b0; start = 1'b1;
        wait_en(4'h7, 60, "rs_reach_0111");
        dn0 = n_dn;
        arst_n = 1'b0;
        cyc(1);
        chk("rs_en", 32'(en), 32'h0);
        chk("rs_stage", 32'(stage), 32'h0);
        chk("rs_busy", 32'(busy), 32'h0);
        chk("rs_pulses", 32'({up_done, down_done}), 32'h0);
        arst_n = 1'b1; start = 1'b0;
        cyc(2);
        chk("rs_stay_idle", 32'(en), 32'h0);
        dly = 8'd0; tick_mode = 0; start = 1'b1;
        wait_en(4'hf, 10, "gl_reach_on");
        cyc(1);
        chk("rs_no_down_done", 32'(n_dn - dn0), 32'd0);
        arst_n = 1'b0; #2; arst_n = 1'b1;
        cyc(1);
        chk("gl_en", 32'(en), 32'hf);
        chk("gl_stage", 32'(stage), 32'd4);

        // Ticks and delay changes in ON are ignored.
        up0 = n_up; dn0 = n_dn;
        tick_mode = 2;
        for (int i = 0; i < 20; i++) begin
            dly = 8'($urandom_range(0, 255));
            cyc(1);
            chk("ign_en", 32'(en), 32'hf);
            chk("ign_busy", 32'(busy), 32'h0);
        end
        chk("ign_no_pulses", 32'((n_up - up0) + (n_dn - dn0)), 32'd0);
        tick_mode = 0;
        cyc(2);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
